// File: rtl/dispatch_queue.sv
// dispatch_queue: N-wide in-order dispatch buffer between rename and ROB/RS.
//
// Renamed instructions are buffered in a circular queue. Up to WIDTH of them are issued
// per cycle, limited by ROB/RS free-slot credits, and each gets a sequential ROB tag that
// wraps modulo ROB_DEPTH. A synchronous flush empties the queue and reloads the tag counter.
//
// Ports:
//   i_clk, i_rst      clock (rising edge), synchronous active-high reset
//   i_flush           synchronous flush, discards every buffered entry
//   i_flush_tag       ROB tag the first instruction after the flush will get
//   i_in_valid        per-lane valids from rename; only the contiguous run from lane 0 is taken
//   i_in_data         per-lane payloads, lane i at [i*PAYLOAD_W +: PAYLOAD_W]
//   o_in_ready        queue can accept a full WIDTH group this cycle
//   i_rob_free        free ROB slots this cycle
//   i_rs_free         free RS slots this cycle
//   o_out_valid       dispatched lane valids, contiguous from lane 0 (registered)
//   o_out_data        dispatched payloads (registered)
//   o_out_tag         ROB tag per dispatched lane (registered)
//
// Optional feature, enabled by defining DISPATCH_QUEUE_STATS_EN:
//   o_stall_cycles    edges where the queue held entries but dispatched none (saturating)
//   o_dispatched      total dispatched instructions (saturating)
//   Both clear on i_rst only; i_flush leaves them untouched.

module dispatch_queue #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned ROB_DEPTH = 16,
  localparam int unsigned TAG_W    = $clog2(ROB_DEPTH),
  localparam int unsigned PTR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W    = PTR_W + 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic [TAG_W-1:0]           i_flush_tag,
  input  logic [WIDTH-1:0]           i_in_valid,
  input  logic [WIDTH*PAYLOAD_W-1:0] i_in_data,
  output logic                       o_in_ready,
  input  logic [TAG_W:0]             i_rob_free,
  input  logic [CNT_W-1:0]           i_rs_free,
  output logic [WIDTH-1:0]           o_out_valid,
  output logic [WIDTH*PAYLOAD_W-1:0] o_out_data,
  output logic [WIDTH*TAG_W-1:0]     o_out_tag
`ifdef DISPATCH_QUEUE_STATS_EN
  ,
  output logic [31:0]                o_stall_cycles,
  output logic [31:0]                o_dispatched
`endif
);

  // Common width for the credit minimum so no operand is truncated before comparison.
  localparam int unsigned KW = (TAG_W + 1 > CNT_W) ? TAG_W + 1 : CNT_W;

  logic [PAYLOAD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [TAG_W-1:0]     r_tag;

  logic [CNT_W-1:0]     w_free;
  logic                 w_in_ready;
  logic [CNT_W-1:0]     w_m;
  logic                 w_run;
  logic [KW-1:0]        w_lim;
  logic [CNT_W-1:0]     w_k;

  // Ready looks only at the registered count, so a same-cycle dispatch never frees space.
  always_comb begin
    w_free     = CNT_W'(DEPTH) - r_count;
    w_in_ready = (w_free >= CNT_W'(WIDTH));
  end

  assign o_in_ready = w_in_ready;

  // Enqueue count: length of the contiguous valid run starting at lane 0.
  always_comb begin
    w_m   = '0;
    w_run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_run && i_in_valid[i]) begin
        w_m = w_m + CNT_W'(1);
      end else begin
        w_run = 1'b0;
      end
    end
    if (!w_in_ready) begin
      w_m = '0;
    end
  end

  // Dispatch count: min(count, WIDTH, rob credits, rs credits), count taken before enqueue.
  always_comb begin
    w_lim = KW'(r_count);
    if (KW'(WIDTH) < w_lim) begin
      w_lim = KW'(WIDTH);
    end
    if (KW'(i_rob_free) < w_lim) begin
      w_lim = KW'(i_rob_free);
    end
    if (KW'(i_rs_free) < w_lim) begin
      w_lim = KW'(i_rs_free);
    end
    w_k = CNT_W'(w_lim);
  end

  // Payload storage; not reset since the count marks which entries are live.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (CNT_W'(i) < w_m) begin
          r_mem[r_wr_ptr + PTR_W'(i)] <= i_in_data[i*PAYLOAD_W +: PAYLOAD_W];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_tag       <= '0;
      o_out_valid <= '0;
      o_out_data  <= '0;
      o_out_tag   <= '0;
    end else if (i_flush) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_tag       <= i_flush_tag;
      o_out_valid <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (CNT_W'(i) < w_k) begin
          o_out_valid[i]                       <= 1'b1;
          o_out_data[i*PAYLOAD_W +: PAYLOAD_W] <= r_mem[r_rd_ptr + PTR_W'(i)];
          o_out_tag[i*TAG_W +: TAG_W]          <= r_tag + TAG_W'(i);
        end else begin
          // Idle lanes drop valid but keep their last data/tag.
          o_out_valid[i] <= 1'b0;
        end
      end
      r_tag    <= r_tag + TAG_W'(w_k);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_k);
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_m);
      r_count  <= r_count + w_m - w_k;
    end
  end

`ifdef DISPATCH_QUEUE_STATS_EN
  logic [32:0] w_stall_sum;
  logic [32:0] w_disp_sum;

  always_comb begin
    w_stall_sum = {1'b0, o_stall_cycles} + 33'd1;
    w_disp_sum  = {1'b0, o_dispatched} + 33'(w_k);
  end

  // Counters freeze on a flush edge: nothing is dispatched there and they survive flushes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cycles <= '0;
      o_dispatched   <= '0;
    end else if (!i_flush) begin
      if ((r_count != '0) && (w_k == '0)) begin
        o_stall_cycles <= w_stall_sum[32] ? 32'hFFFF_FFFF : w_stall_sum[31:0];
      end
      o_dispatched <= w_disp_sum[32] ? 32'hFFFF_FFFF : w_disp_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue (WIDTH=2, DEPTH=8, PAYLOAD_W=64, ROB_DEPTH=16).
// Payloads go into a scoreboard queue when accepted and are popped as lanes dispatch;
// tags are checked against an independent running tag counter.

module tb_dispatch_queue;

  localparam int W  = 2;
  localparam int D  = 8;
  localparam int PW = 64;
  localparam int RD = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [3:0]   flush_tag;
  logic [1:0]   in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic [4:0]   rob_free;
  logic [3:0]   rs_free;
  logic [1:0]   out_valid;
  logic [127:0] out_data;
  logic [7:0]   out_tag;
`ifdef DISPATCH_QUEUE_STATS_EN
  logic [31:0]  stall_cycles;
  logic [31:0]  dispatched;
`endif

  always #5 clk = ~clk;

  dispatch_queue #(
    .WIDTH    (W),
    .DEPTH    (D),
    .PAYLOAD_W(PW),
    .ROB_DEPTH(RD)
  ) u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_flush       (flush),
    .i_flush_tag   (flush_tag),
    .i_in_valid    (in_valid),
    .i_in_data     (in_data),
    .o_in_ready    (in_ready),
    .i_rob_free    (rob_free),
    .i_rs_free     (rs_free),
    .o_out_valid   (out_valid),
    .o_out_data    (out_data),
    .o_out_tag     (out_tag)
`ifdef DISPATCH_QUEUE_STATS_EN
    ,
    .o_stall_cycles(stall_cycles),
    .o_dispatched  (dispatched)
`endif
  );

  logic [63:0] sb[$];
  int          mcount;
  logic [3:0]  exp_tag;
  int          n_chk;
  int          n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pl(input int n);
    return 64'hD15C_0000_0000_0000 | 64'(n);
  endfunction

  // One cycle: drive lanes/credits, predict accept and dispatch count, check outputs after edge.
  task automatic drive(input logic [1:0] v, input int a, input int b, input int rob,
                       input int rs);
    int m;
    int k;
    logic [63:0] e;
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(mcount <= D - W));
    in_valid = v;
    in_data  = {pl(b), pl(a)};
    rob_free = 5'(rob);
    rs_free  = 4'(rs);
    flush    = 1'b0;
    m = 0;
    if (mcount <= D - W && v[0]) m = v[1] ? 2 : 1;
    if (m >= 1) sb.push_back(pl(a));
    if (m == 2) sb.push_back(pl(b));
    k = mcount;
    if (k > W) k = W;
    if (rob < k) k = rob;
    if (rs < k) k = rs;
    @(posedge clk);
    #1;
    mcount = mcount + m - k;
    chk("out_valid", 64'(out_valid), (k == 2) ? 64'd3 : (k == 1) ? 64'd1 : 64'd0);
    for (int i = 0; i < k; i++) begin
      e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
      chk("out_data", out_data[i*64 +: 64], e);
      chk("out_tag", 64'(out_tag[i*4 +: 4]), 64'(exp_tag));
      exp_tag = exp_tag + 4'd1;
    end
  endtask

  task automatic do_flush(input logic [3:0] ft, input logic [1:0] v, input int a, input int b);
    @(negedge clk);
    in_valid  = v;
    in_data   = {pl(b), pl(a)};
    rob_free  = 5'd16;
    rs_free   = 4'd8;
    flush     = 1'b1;
    flush_tag = ft;
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb.delete();
    mcount  = 0;
    exp_tag = ft;
    chk("flush_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 2'b00;
    @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data_lo", out_data[63:0], 64'd0);
    chk("rst_data_hi", out_data[127:64], 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    mcount  = 0;
    exp_tag = 4'd0;
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    mcount    = 0;
    exp_tag   = 4'd0;
    rst       = 1'b1;
    flush     = 1'b0;
    flush_tag = 4'd0;
    in_valid  = 2'b00;
    in_data   = '0;
    rob_free  = 5'd0;
    rs_free   = 4'd0;
    repeat (2) @(posedge clk);
    do_reset();

    // Basic pair: visible two edges after enqueue with tags 0,1.
    drive(2'b11, 1, 2, 16, 8);
    drive(2'b00, 0, 0, 16, 8);

    // No ROB credit: fill to 8, ready drops, then trickle one lane per cycle.
    for (int g = 0; g < 4; g++) drive(2'b11, 10 + 2 * g, 11 + 2 * g, 0, 8);
    drive(2'b11, 90, 91, 1, 8);
    repeat (8) drive(2'b00, 0, 0, 1, 8);

    // Lane 0 invalid drops the group; lane 0 alone enqueues one entry.
    drive(2'b10, 20, 21, 0, 8);
    drive(2'b01, 22, 23, 0, 8);
    drive(2'b00, 0, 0, 16, 8);
    drive(2'b00, 0, 0, 16, 8);

    // Tag wrap from 15, then streaming traffic that wraps the queue pointers.
    do_flush(4'd15, 2'b00, 0, 0);
    drive(2'b11, 30, 31, 16, 8);
    drive(2'b11, 32, 33, 16, 8);
    drive(2'b00, 0, 0, 16, 8);
    for (int j = 0; j < 12; j++) drive(2'b11, 40 + 2 * j, 41 + 2 * j, 16, (j % 3 == 0) ? 1 : 2);
    repeat (6) drive(2'b00, 0, 0, 16, 8);

    // Flush with 6 queued and a same-edge enqueue; next dispatch starts at tag 9.
    for (int g = 0; g < 3; g++) drive(2'b11, 60 + 2 * g, 61 + 2 * g, 0, 8);
    do_flush(4'd9, 2'b11, 70, 71);
    drive(2'b11, 72, 73, 16, 8);
    drive(2'b00, 0, 0, 16, 8);
    drive(2'b00, 0, 0, 16, 8);

    // Reset mid-operation discards buffered entries.
    drive(2'b11, 74, 75, 0, 8);
    drive(2'b11, 76, 77, 0, 8);
    do_reset();
    drive(2'b00, 0, 0, 16, 8);
    drive(2'b00, 0, 0, 16, 8);

`ifdef DISPATCH_QUEUE_STATS_EN
    do_reset();
    drive(2'b11, 80, 81, 0, 8);
    drive(2'b11, 82, 83, 0, 8);
    drive(2'b01, 84, 0, 0, 8);
    drive(2'b00, 0, 0, 0, 8);
    repeat (3) drive(2'b00, 0, 0, 16, 8);
    chk("stall_cycles", 64'(stall_cycles), 64'd3);
    chk("dispatched", 64'(dispatched), 64'd5);
    do_flush(4'd0, 2'b00, 0, 0);
    chk("stall_after_flush", 64'(stall_cycles), 64'd3);
    chk("disp_after_flush", 64'(dispatched), 64'd5);
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
